// File: rtl/multi_regfile_if.sv
// Bus bundle for multi_regfile: three read ports, two write ports and the busy flag.
// The master side drives addresses, write data and enables; the slave side returns read data and busy.
interface multi_regfile_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] r_addr_1;
    logic [ADDR_W-1:0] r_addr_2;
    logic [ADDR_W-1:0] r_addr_3;
    logic [WIDTH-1:0]  data_out_1;
    logic [WIDTH-1:0]  data_out_2;
    logic [WIDTH-1:0]  data_out_3;
    logic [ADDR_W-1:0] w_addr_a;
    logic [ADDR_W-1:0] w_addr_b;
    logic [WIDTH-1:0]  data_in_a;
    logic [WIDTH-1:0]  data_in_b;
    logic              we_a;
    logic              we_b;
    logic              busy;

    modport master (
        output r_addr_1, r_addr_2, r_addr_3,
        output w_addr_a, w_addr_b, data_in_a, data_in_b, we_a, we_b,
        input  data_out_1, data_out_2, data_out_3, busy
    );

    modport slave (
        input  r_addr_1, r_addr_2, r_addr_3,
        input  w_addr_a, w_addr_b, data_in_a, data_in_b, we_a, we_b,
        output data_out_1, data_out_2, data_out_3, busy
    );
endinterface

// File: rtl/multi_regfile.sv
// 3-read / 2-write register file with a post-reset clear sequence that zeroes every entry.
// Define MULTI_REGFILE_BYPASS_EN for write-through reads (port B beats port A); default reads stored data.
module multi_regfile #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic           clk,
    input logic           rst,
    multi_regfile_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_wr_a;
    logic              w_wr_b;
    logic [ADDR_W-1:0] w_raddr [3];
    logic [WIDTH-1:0]  w_rdata [3];

    // Port A yields to port B on a shared address; entry 0 is read-only when ZERO_REG is set.
    assign w_wr_a = bus.we_a
                    && !((ZERO_REG != 0) && (bus.w_addr_a == '0))
                    && !(bus.we_b && (bus.w_addr_b == bus.w_addr_a));
    assign w_wr_b = bus.we_b && !((ZERO_REG != 0) && (bus.w_addr_b == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else begin
                if (w_wr_a) begin
                    r_mem[bus.w_addr_a] <= bus.data_in_a;
                end
                if (w_wr_b) begin
                    r_mem[bus.w_addr_b] <= bus.data_in_b;
                end
            end
        end
    end

    assign w_raddr[0] = bus.r_addr_1;
    assign w_raddr[1] = bus.r_addr_2;
    assign w_raddr[2] = bus.r_addr_3;

    // Busy and the zero register override everything, including any bypassed write data.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_rdata[i] = r_mem[w_raddr[i]];
`ifdef MULTI_REGFILE_BYPASS_EN
            if (bus.we_a && (w_raddr[i] == bus.w_addr_a)) begin
                w_rdata[i] = bus.data_in_a;
            end
            if (bus.we_b && (w_raddr[i] == bus.w_addr_b)) begin
                w_rdata[i] = bus.data_in_b;
            end
`endif
            if (r_busy || ((ZERO_REG != 0) && (w_raddr[i] == '0))) begin
                w_rdata[i] = '0;
            end
        end
    end

    assign bus.data_out_1 = w_rdata[0];
    assign bus.data_out_2 = w_rdata[1];
    assign bus.data_out_3 = w_rdata[2];
    assign bus.busy       = r_busy;
endmodule

// File: doc/multi_regfile.md
MULTI_REGFILE -- requirements
Module: multi_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary.
REQ-004 SHALL have the port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have the ports r_addr_1 / r_addr_2 / r_addr_3, input, ADDR_W bits each: read addresses.
REQ-007 SHALL have the ports data_out_1 / data_out_2 / data_out_3, output, WIDTH bits each: read data.
REQ-008 SHALL have the ports w_addr_a / w_addr_b, input, ADDR_W bits each: write addresses.
REQ-009 SHALL have the ports data_in_a / data_in_b, input, WIDTH bits each: write data.
REQ-010 SHALL have the ports we_a / we_b, input, 1 bit each: write enables, active-high.
REQ-011 SHALL have the port busy, output, 1 bit: high while reset or the clear sequence is in progress.

Function
REQ-012 SHALL read combinationally: data_out_n = entry[r_addr_n] in the same cycle, with no clock latency.
REQ-013 SHALL perform writes on the rising edge of clk when we_x=1 and busy=0, with 1-cycle latency to storage.
REQ-014 SHALL, when both ports write the same address in one cycle, store data_in_b (port B wins); port A's write is discarded.
REQ-015 SHALL, when both ports write different addresses in one cycle, store both.
REQ-016 SHALL, with ZERO_REG=1, return 0 on any read of address 0 and drop writes to address 0 on either port.
REQ-017 SHALL implement a clear FSM with states IDLE and CLEAR, plus a pointer clr_ptr of ADDR_W bits.
REQ-018 SHALL, in CLEAR, write 0 to entry[clr_ptr] each cycle and increment clr_ptr.
REQ-019 SHALL transition CLEAR->IDLE on the cycle that clears entry DEPTH-1; there is no wrap-around of clr_ptr.
REQ-020 SHALL drive busy=1 in CLEAR and busy=0 in IDLE.
REQ-021 SHALL, while busy=1, force all data_out_n to 0 and ignore we_a and we_b.
REQ-022 SHALL make the clear sequence last exactly DEPTH cycles after rst deasserts; busy falls on the DEPTH-th rising edge after rst low.
REQ-023 SHALL NOT introduce any delay constructs in the RTL; ordering is determined by clock edges only.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, set state=CLEAR and clr_ptr=0, regardless of the current state.
REQ-025 SHALL hold busy=1 and all data_out_n=0 during and immediately after reset.
REQ-026 SHALL, if rst is asserted mid-CLEAR, restart clearing at clr_ptr=0.
REQ-027 SHALL, if rst is asserted mid-IDLE, discard any write presented in that cycle.
REQ-028 SHALL hold every entry at 0 after the clear sequence completes.

Configuration
REQ-029 SHALL support the macro MULTI_REGFILE_BYPASS_EN to select write-through read behaviour.
REQ-030 SHALL, when MULTI_REGFILE_BYPASS_EN is defined and busy=0, have a read port whose r_addr matches an enabled write address return that write's data_in in the same cycle, with port B taking priority over port A. The ZERO_REG rule still wins at address 0.
REQ-031 SHALL, when MULTI_REGFILE_BYPASS_EN is undefined, return the stored value on reads, with new data visible the cycle after the write edge.

Verification
REQ-032 SHALL be verified with: rst high 2 cycles, then low (ADDR_W=5) -> busy=1 for exactly 32 cycles, then 0; all reads of 0..31 return 0.
REQ-033 SHALL be verified with: we_a=1, w_addr_a=5, data_in_a=0xDEADBEEF; we_b=1, w_addr_b=5, data_in_b=0x12345678 -> next cycle r_addr_1=5 gives 0x12345678.
REQ-034 SHALL be verified with: ZERO_REG=1, we_a=1, w_addr_a=0, data_in_a=0xFFFFFFFF -> data_out_1 at r_addr_1=0 is 0 afterwards.
REQ-035 SHALL be verified with: with bypass enabled, we_a=1, w_addr_a=7, data_in_a=0xA5A5A5A5, r_addr_2=7 in the same cycle -> data_out_2=0xA5A5A5A5 that cycle. With bypass disabled -> old value that cycle, 0xA5A5A5A5 the next cycle.
REQ-036 SHALL be verified with: rst pulsed at clear cycle 10 -> busy stays 1 for 32 more cycles from rst deassert; a write attempted during busy is absent afterwards.
REQ-037 SHALL be verified with: WIDTH=16, ADDR_W=3, dual writes to 2 and 6 with values 0x1111 and 0x6666 -> reads return both values, and busy after reset lasts 8 cycles.
